io_mmio_bridge: RTL

Parametrised memory-mapped I/O bridge between the processor's data-memory port and the data RAM. It generalises the fixed special-register I/O (dedicated registers, a button signal and a screen signal) into N_IN input channels and N_OUT output channels, all reached with ordinary load/store instructions. Each input channel carries a synchronised, edge-detected, sticky event flag. The bridge sits in the top-level wrapper; non-I/O accesses pass through to the RAM unchanged, with matching read latency.

---
 rtl/io_mmio_bridge.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/io_mmio_bridge.sv
// io_mmio_bridge
//   Memory-mapped I/O bridge between the processor data-memory port and the
//   data RAM. Loads and stores whose address falls in the 256-word I/O window
//   at IO_BASE reach N_IN input channels, N_OUT output channels and a sticky,
//   read-to-clear event register. All other accesses pass through to the RAM.
//   Reads have the same 1-cycle latency as the RAM.
//
// Ports
//   clock, reset    system clock, synchronous active-high reset
//   cpu_wren        processor store enable
//   cpu_addr        processor word address
//   cpu_data        processor store data
//   cpu_q           load data to processor (I/O word or RAM data)
//   ram_wren        RAM write enable, suppressed for I/O stores
//   ram_addr        RAM address, pass-through of cpu_addr
//   ram_data        RAM write data, pass-through of cpu_data
//   ram_q           RAM read data, 1-cycle latency
//   in_data         input channel words, channel i at [32i+31:32i]
//   in_event        asynchronous event lines, one per input channel
//   out_data        output channel registers, channel i at [32i+31:32i]
//   out_strobe      one-cycle pulse following each store to a channel
//
// Register map (offset = cpu_addr[7:0])
//   0x00+i  OUT[i]  read/write (i < N_OUT)
//   0x10+i  IN[i]   read-only  (i < N_IN)
//   0x20    EVT     sticky event flags, read-to-clear
//   0x21    LVL     synchronised event levels, read-only
//   others  read 0, writes ignored

module io_mmio_bridge #(
  parameter int          N_IN    = 4,
  parameter int          N_OUT   = 4,
  parameter logic [11:0] IO_BASE = 12'hF00
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_wren,
  input  logic [11:0]           cpu_addr,
  input  logic [31:0]           cpu_data,
  output logic [31:0]           cpu_q,
  output logic                  ram_wren,
  output logic [11:0]           ram_addr,
  output logic [31:0]           ram_data,
  input  logic [31:0]           ram_q,
  input  logic [32*N_IN-1:0]    in_data,
  input  logic [N_IN-1:0]       in_event,
  output logic [32*N_OUT-1:0]   out_data,
  output logic [N_OUT-1:0]      out_strobe
);

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned OFF_W    = 8;
  localparam int unsigned IN_BASE  = 16;
  localparam logic [OFF_W-1:0] EVT_OFF = 8'h20;
  localparam logic [OFF_W-1:0] LVL_OFF = 8'h21;

  // Window decode
  logic             hit;
  logic [OFF_W-1:0] off;

  assign hit = (cpu_addr[11:8] == IO_BASE[11:8]);
  assign off = cpu_addr[OFF_W-1:0];

  // RAM side: address/data pass straight through, only the write enable is gated
  assign ram_wren = cpu_wren & ~hit;
  assign ram_addr = cpu_addr;
  assign ram_data = cpu_data;

  // State
  logic [N_OUT-1:0][WORD_W-1:0] out_q;
  logic [N_IN-1:0]              s1_q;
  logic [N_IN-1:0]              s2_q;
  logic [N_IN-1:0]              p_q;
  logic [N_IN-1:0]              evt_q;
  logic                         hit_q;
  logic [WORD_W-1:0]            io_rd_q;

  assign out_data = out_q;

  // Rising edge of the synchronised event level
  logic [N_IN-1:0] rise;
  assign rise = s2_q & ~p_q;

  // A load of EVT clears the flags at the same edge it samples them
  logic evt_rd;
  assign evt_rd = hit & ~cpu_wren & (off == EVT_OFF);

  // Per-channel store select
  logic [N_OUT-1:0] wr_sel;
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < N_OUT; i++) begin
      wr_sel[i] = cpu_wren & hit & (off == OFF_W'(i));
    end
  end

  // Read mux. Input words are taken from in_data as it is registered at the
  // address edge, so the load returns the value captured at that edge.
  logic [WORD_W-1:0] rd_word;
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (off == OFF_W'(i)) rd_word = out_q[i];
    end
    for (int i = 0; i < N_IN; i++) begin
      if (off == OFF_W'(IN_BASE + i)) rd_word = in_data[WORD_W*i +: WORD_W];
    end
    if (off == EVT_OFF) rd_word = WORD_W'(evt_q);
    if (off == LVL_OFF) rd_word = WORD_W'(s2_q);
  end

  // Sequential state; reset overrides any store, clear or event at the edge
  always_ff @(posedge clock) begin
    if (reset) begin
      out_q      <= '0;
      out_strobe <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      p_q        <= '0;
      evt_q      <= '0;
      hit_q      <= 1'b0;
      io_rd_q    <= '0;
    end else begin
      s1_q <= in_event;
      s2_q <= s1_q;
      p_q  <= s2_q;
      // A clearing read keeps bits that rise at the same edge
      evt_q <= evt_rd ? rise : (evt_q | rise);
      for (int i = 0; i < N_OUT; i++) begin
        if (wr_sel[i]) out_q[i] <= cpu_data;
      end
      out_strobe <= wr_sel;
      hit_q      <= hit;
      io_rd_q    <= rd_word;
    end
  end

  // Load return: I/O word for window hits, RAM data otherwise
  assign cpu_q = hit_q ? io_rd_q : ram_q;

endmodule
